// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, instruction geometry and
// small address helpers used by the fetch sequencer and its PC unit.
package rv32i_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] INSTR_BYTES  = 32'd4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // Force an address onto a 4-byte instruction boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    // True when the low address bits do not describe a word boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_reg_unit.sv
// Architectural PC register with sequential +4 advance, redirect mux
// (redirect wins and is forced word-aligned) and misalignment flag.
module pc_reg_unit
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            seq_load,
    input  logic [XLEN-1:0] seq_base,
    output logic [XLEN-1:0] pc,
    output logic            misalign_pulse
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic            misalign_r;

    // Next-PC selection: redirect target first, then sequential advance, else hold.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect) begin
            pc_next_s = align_word(redirect_pc);
        end else if (seq_load) begin
            pc_next_s = seq_base + INSTR_BYTES;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register and one-cycle misalignment flag, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
        end else begin
            pc_r       <= pc_next_s;
            misalign_r <= redirect && is_misaligned(redirect_pc[1:0]);
        end
    end

    assign pc             = pc_r;
    assign misalign_pulse = misalign_r;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request at a time,
// registered {pc, instr} presentation to decode, and flush of wrong-path
// fetches when execute redirects.
module fetch_pc_ctrl
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            misalign_pulse
);

    fetch_state_t    state_r;
    logic            drop_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic            if_valid_r;
    logic [XLEN-1:0] if_pc_r;
    logic [31:0]     if_instr_r;
    logic [XLEN-1:0] pc_s;
    logic            req_hs_s;
    logic            seq_load_s;

    assign req_hs_s   = (state_r == S_REQ) && imem_req_ready;
    // Only a good (not stale) response advances the PC; redirect priority is in the PC unit.
    assign seq_load_s = (state_r == S_WAIT) && imem_rsp_valid && !drop_r;

    pc_reg_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .seq_load       (seq_load_s),
        .seq_base       (fetch_pc_r),
        .pc             (pc_s),
        .misalign_pulse (misalign_pulse)
    );

    // Fetch FSM with registered decode-side outputs and stale-response tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_REQ;
            drop_r     <= 1'b0;
            fetch_pc_r <= RESET_PC;
            if_valid_r <= 1'b0;
            if_pc_r    <= '0;
            if_instr_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (req_hs_s) begin
                        fetch_pc_r <= pc_s;
                        drop_r     <= redirect;
                        state_r    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_r || redirect) begin
                            // Wrong-path response: discard and refetch from the new PC.
                            drop_r  <= 1'b0;
                            state_r <= S_REQ;
                        end else begin
                            if_instr_r <= imem_rsp_data;
                            if_pc_r    <= fetch_pc_r;
                            if_valid_r <= 1'b1;
                            state_r    <= S_HOLD;
                        end
                    end else if (redirect) begin
                        drop_r <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect flushes the held instruction even if decode accepts it.
                    if (redirect || if_ready) begin
                        if_valid_r <= 1'b0;
                        state_r    <= S_REQ;
                    end
                end
                default: begin
                    state_r    <= S_REQ;
                    drop_r     <= 1'b0;
                    if_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = (state_r == S_REQ);
    assign imem_req_addr  = pc_s;
    assign if_valid       = if_valid_r;
    assign if_pc          = if_pc_r;
    assign if_instr       = if_instr_r;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed tests push expected request
// addresses and decode deliveries; a negedge monitor pops and compares.
module tb_fetch_pc_ctrl;
    import rv32i_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0000_0000;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = 32'h0000_0000;
    logic        if_valid;
    logic        if_ready       = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_pulse;

    logic [31:0] exp_req_q[$];
    if_exp_t     exp_if_q[$];
    int          if_cyc_q[$];
    int          cyc_cnt = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;

    fetch_pc_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign_pulse (misalign_pulse)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used for cadence measurements.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: mid-cycle sampling of request and decode handshakes against the queues.
    initial begin
        if_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_req", imem_req_addr, 32'hFFFF_FFFF);
                end else begin
                    check("req_addr", imem_req_addr, exp_req_q.pop_front());
                end
            end
            if (!rst && if_valid && if_ready && !redirect) begin
                if_cyc_q.push_back(cyc_cnt);
                if (exp_if_q.size() == 0) begin
                    check("unexpected_if_pc", if_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_if_q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_instr", if_instr, e.instr);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer the request channel until the DUT's request is accepted.
    task automatic req_hs();
        bit got = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (imem_req_valid) got = 1'b1;
            cyc();
        end
        imem_req_ready = 1'b0;
        check("req_hs_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic rsp_pulse(input logic [31:0] data, input int lat);
        repeat (lat - 1) cyc();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        cyc();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] data, input int lat);
        req_hs();
        rsp_pulse(data, lat);
    endtask

    task automatic push_if(input logic [31:0] pc, input logic [31:0] instr);
        if_exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_if_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect = 1'b0;
        if_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        if_cyc_q.delete();
    endtask

    task automatic drain(input string name);
        repeat (3) cyc();
        check({name, "_req_left"}, exp_req_q.size(), 32'd0);
        check({name, "_if_left"}, exp_if_q.size(), 32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed test sequence.
    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) cyc();
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_misalign", {31'd0, misalign_pulse}, 32'd0);
        rst = 1'b0;
        cyc();
        check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("post_rst_req_addr", imem_req_addr, 32'h0);

        // 1. Sequential fetch at 3-cycle cadence
        do_reset();
        if_ready = 1'b1;
        exp_req_q.push_back(32'h0); push_if(32'h0, NOP_INSTR);
        exp_req_q.push_back(32'h4); push_if(32'h4, 32'h0000_0017);
        exp_req_q.push_back(32'h8); push_if(32'h8, 32'h0000_001B);
        fetch_one(NOP_INSTR, 1);
        fetch_one(32'h0000_0017, 1);
        fetch_one(32'h0000_001B, 1);
        drain("seq");
        check("seq_deliveries", if_cyc_q.size(), 32'd3);
        if (if_cyc_q.size() == 3) begin
            check("cadence_0", if_cyc_q[1] - if_cyc_q[0], 32'd3);
            check("cadence_1", if_cyc_q[2] - if_cyc_q[1], 32'd3);
        end

        // 2. Decode stall holds outputs and blocks new requests
        do_reset();
        exp_req_q.push_back(32'h0); push_if(32'h0, NOP_INSTR);
        fetch_one(NOP_INSTR, 1);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_if_valid", {31'd0, if_valid}, 32'd1);
            check("stall_if_pc", if_pc, 32'h0);
            check("stall_if_instr", if_instr, NOP_INSTR);
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
            cyc();
        end
        imem_req_ready = 1'b0;
        if_ready = 1'b1;
        exp_req_q.push_back(32'h4); push_if(32'h4, 32'h0000_0017);
        fetch_one(32'h0000_0017, 2);
        drain("stall");

        // 3. Redirect while 0x10 is in flight
        do_reset();
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_req_q.push_back(32'(i * 4));
            push_if(32'(i * 4), 32'(i * 4) ^ NOP_INSTR);
            fetch_one(32'(i * 4) ^ NOP_INSTR, 1);
        end
        exp_req_q.push_back(32'h10);
        req_hs();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cyc();
        redirect = 1'b0;
        check("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
        rsp_pulse(32'hDEAD_BEEF, 2);
        exp_req_q.push_back(32'h100); push_if(32'h100, 32'h0000_0113);
        fetch_one(32'h0000_0113, 1);
        drain("redir_wait");

        // 4a. Redirect coincident with the response
        do_reset();
        if_ready = 1'b1;
        exp_req_q.push_back(32'h0);
        req_hs();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000;
        cyc();
        redirect = 1'b0; imem_rsp_valid = 1'b0;
        check("same_cyc_if_valid", {31'd0, if_valid}, 32'd0);
        // 4b. Redirect with if_ready while holding 0x200
        if_ready = 1'b0;
        exp_req_q.push_back(32'h200);
        fetch_one(32'hBAD0_0200, 1);
        redirect = 1'b1; redirect_pc = 32'h0000_0300; if_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        check("hold_flush_if_valid", {31'd0, if_valid}, 32'd0);
        check("hold_flush_addr", imem_req_addr, 32'h300);
        exp_req_q.push_back(32'h300); push_if(32'h300, 32'h0000_0313);
        fetch_one(32'h0000_0313, 1);
        drain("flush");

        // 5. Misaligned redirect, then PC wrap at the top of memory
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        cyc();
        redirect = 1'b0;
        check("misalign_set", {31'd0, misalign_pulse}, 32'd1);
        check("misalign_addr", imem_req_addr, 32'h100);
        cyc();
        check("misalign_clear", {31'd0, misalign_pulse}, 32'd0);
        if_ready = 1'b1;
        exp_req_q.push_back(32'h100); push_if(32'h100, 32'h0000_0113);
        fetch_one(32'h0000_0113, 1);
        cyc();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        check("aligned_no_misalign", {31'd0, misalign_pulse}, 32'd0);
        exp_req_q.push_back(32'hFFFF_FFFC); push_if(32'hFFFF_FFFC, 32'hFFFF_FFEF);
        fetch_one(32'hFFFF_FFEF, 1);
        exp_req_q.push_back(32'h0); push_if(32'h0, NOP_INSTR);
        fetch_one(NOP_INSTR, 1);
        drain("wrap");

        // 6. Reset during S_WAIT followed by a late response
        do_reset();
        exp_req_q.push_back(32'h0);
        req_hs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0BAD;
        cyc();
        imem_rsp_valid = 1'b0;
        check("late_rsp_if_valid", {31'd0, if_valid}, 32'd0);
        check("late_rsp_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("late_rsp_req_addr", imem_req_addr, 32'h0);
        if_ready = 1'b1;
        exp_req_q.push_back(32'h0); push_if(32'h0, NOP_INSTR);
        fetch_one(NOP_INSTR, 1);
        drain("late_rsp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
